// File: rtl/chunked_add_sub.sv
// Multi-cycle add/subtract: WIDTH-bit operands summed CHUNK bits per clock with a registered carry.
// Optional signed-overflow output enabled by defining ADD_OVERFLOW_EN.
module chunked_add_sub #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [1:0]       dbg_state,
  output logic [WIDTH-1:0] s,
  output logic             cout
`ifdef ADD_OVERFLOW_EN
  ,
  output logic             ovf
`endif
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NCHUNK - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Handshakes: a transfer occurs on a rising edge where valid && ready.
  // in_ready is high only in IDLE; out_valid is high only in DONE and holds until out_ready.
  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             carry_q, carry_d;
  logic [IDXW-1:0]  idx_q, idx_d;
  logic [WIDTH-1:0] s_q, s_d;
  logic             cout_q, cout_d;
`ifdef ADD_OVERFLOW_EN
  logic             ovf_q, ovf_d;
`endif

  logic [CHUNK-1:0] a_chunk;
  logic [CHUNK-1:0] b_chunk;
  logic [CHUNK:0]   chunk_sum;

  always_comb begin
    a_chunk   = a_q[int'(idx_q)*CHUNK +: CHUNK];
    b_chunk   = b_q[int'(idx_q)*CHUNK +: CHUNK];
    chunk_sum = {1'b0, a_chunk} + {1'b0, b_chunk} + {{CHUNK{1'b0}}, carry_q};
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    carry_d = carry_q;
    idx_d   = idx_q;
    s_d     = s_q;
    cout_d  = cout_q;
`ifdef ADD_OVERFLOW_EN
    ovf_d   = ovf_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          // Subtraction is a + ~b + !cin, so the inverted operand and carry are stored.
          a_d     = a;
          b_d     = sub ? ~b : b;
          carry_d = cin ^ sub;
          idx_d   = '0;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        s_d[int'(idx_q)*CHUNK +: CHUNK] = chunk_sum[CHUNK-1:0];
        carry_d = chunk_sum[CHUNK];
        if (idx_q == LAST_IDX) begin
          cout_d  = chunk_sum[CHUNK];
`ifdef ADD_OVERFLOW_EN
          // Carry into the MSB recovered from the MSB sum bit and its operand bits.
          ovf_d   = (a_q[WIDTH-1] ^ b_q[WIDTH-1] ^ chunk_sum[CHUNK-1]) ^ chunk_sum[CHUNK];
`endif
          idx_d   = '0;
          state_d = ST_DONE;
        end else begin
          idx_d = idx_q + IDXW'(1);
        end
      end
      ST_DONE: begin
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      carry_q <= 1'b0;
      idx_q   <= '0;
      s_q     <= '0;
      cout_q  <= 1'b0;
`ifdef ADD_OVERFLOW_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      carry_q <= carry_d;
      idx_q   <= idx_d;
      s_q     <= s_d;
      cout_q  <= cout_d;
`ifdef ADD_OVERFLOW_EN
      ovf_q   <= ovf_d;
`endif
    end
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign dbg_state = state_q;
  assign s         = s_q;
  assign cout      = cout_q;
`ifdef ADD_OVERFLOW_EN
  assign ovf       = ovf_q;
`endif

endmodule

// File: tb/tb_chunked_add_sub.sv
// Directed + random bench for chunked_add_sub (WIDTH=32, CHUNK=8) with a queue-based scoreboard.
module tb_chunked_add_sub;
  localparam int WIDTH  = 32;
  localparam int CHUNK  = 8;
  localparam int NCHUNK = WIDTH / CHUNK;

  logic             clk;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [1:0]       dbg_state;
  logic [WIDTH-1:0] s;
  logic             cout;
`ifdef ADD_OVERFLOW_EN
  logic             ovf;
`endif

  int checks = 0;
  int errors = 0;
  // Each entry is {ovf, cout, s}.
  logic [WIDTH+1:0] exp_q[$];

  chunked_add_sub #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .sub(sub), .out_valid(out_valid), .out_ready(out_ready),
    .dbg_state(dbg_state), .s(s), .cout(cout)
`ifdef ADD_OVERFLOW_EN
    , .ovf(ovf)
`endif
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [WIDTH+1:0] model(input logic [WIDTH-1:0] ma, input logic [WIDTH-1:0] mb,
                                             input logic mcin, input logic msub);
    logic [WIDTH-1:0] be;
    logic [WIDTH:0]   r;
    logic             o;
    be = msub ? ~mb : mb;
    r  = {1'b0, ma} + {1'b0, be} + {{WIDTH{1'b0}}, (msub ? ~mcin : mcin)};
    o  = (ma[WIDTH-1] == be[WIDTH-1]) && (r[WIDTH-1] != ma[WIDTH-1]);
    return {o, r};
  endfunction

  // Driver: present one operand set, push its expectation, scramble inputs after the accept edge.
  task automatic issue(input logic [WIDTH-1:0] ia, input logic [WIDTH-1:0] ib,
                       input logic icin, input logic isub, input bit score);
    int n;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("in_ready_wait", 64'(n < 50), 64'(1));
    in_valid = 1'b1;
    a = ia; b = ib; cin = icin; sub = isub;
    if (score) exp_q.push_back(model(ia, ib, icin, isub));
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    a = $urandom; b = $urandom;
    cin = 1'($urandom_range(1)); sub = 1'($urandom_range(1));
  endtask

  // Wait (bounded) for out_valid, check latency and result against the scoreboard.
  task automatic collect(input string tag);
    int lat;
    logic [WIDTH+1:0] e;
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check({tag, "_latency"}, 64'(lat), 64'(NCHUNK));
    if (exp_q.size() == 0) begin
      check({tag, "_queue_empty"}, 64'(0), 64'(1));
    end else begin
      e = exp_q.pop_front();
      check({tag, "_s"}, 64'(s), 64'(e[WIDTH-1:0]));
      check({tag, "_cout"}, 64'(cout), 64'(e[WIDTH]));
`ifdef ADD_OVERFLOW_EN
      check({tag, "_ovf"}, 64'(ovf), 64'(e[WIDTH+1]));
`endif
    end
  endtask

  task automatic release_result(input string tag);
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check({tag, "_rel_out_valid"}, 64'(out_valid), 64'(0));
    check({tag, "_rel_in_ready"}, 64'(in_ready), 64'(1));
  endtask

  initial begin
    logic [WIDTH-1:0] held_s;
    logic             held_c;
    logic             seen;
    logic [WIDTH-1:0] ra, rb;
    logic             rc, rs;

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; cin = 1'b0; sub = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_out_valid", 64'(out_valid), 64'(0));
    check("reset_s", 64'(s), 64'(0));
    check("reset_cout", 64'(cout), 64'(0));
    check("reset_in_ready", 64'(in_ready), 64'(1));
    @(negedge clk);
    rst_n = 1'b1;

    // 1: no carry anywhere
    issue(32'h8000_0000, 32'h7FFF_FFFF, 1'b0, 1'b0, 1'b1);
    check("t1_s_const", 64'(exp_q[0][WIDTH-1:0] == 32'hFFFF_FFFF), 64'(1));
    collect("t1");
    release_result("t1");

    // 2: carry ripples through every chunk
    issue(32'hFFFF_FFFF, 32'h0000_0001, 1'b1, 1'b0, 1'b1);
    collect("t2");
    check("t2_s_direct", 64'(s), 64'h1);
    check("t2_cout_direct", 64'(cout), 64'h1);
    release_result("t2");

    // 3: subtraction with and without borrow
    issue(32'd5, 32'd7, 1'b0, 1'b1, 1'b1);
    collect("t3a");
    check("t3a_s_direct", 64'(s), 64'hFFFF_FFFE);
    release_result("t3a");
    issue(32'd7, 32'd5, 1'b0, 1'b1, 1'b1);
    collect("t3b");
    check("t3b_s_direct", 64'(s), 64'h2);
    check("t3b_cout_direct", 64'(cout), 64'h1);
    release_result("t3b");
    issue(32'd9, 32'd4, 1'b1, 1'b1, 1'b1);
    collect("t3c");
    release_result("t3c");

    // 4: back-pressure in DONE with in_valid pulsing
    issue(32'h1234_5678, 32'h0F0F_F0F0, 1'b1, 1'b0, 1'b1);
    collect("t4");
    held_s = 32'h1234_5678 + 32'h0F0F_F0F0 + 32'd1;
    held_c = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      a = $urandom; b = $urandom;
      @(posedge clk);
      #1;
      check("t4_hold_out_valid", 64'(out_valid), 64'(1));
      check("t4_hold_s", 64'(s), 64'(held_s));
      check("t4_hold_cout", 64'(cout), 64'(held_c));
      check("t4_hold_in_ready", 64'(in_ready), 64'(0));
    end
    @(negedge clk);
    in_valid = 1'b0;
    release_result("t4");
    check("t4_queue_empty", 64'(exp_q.size()), 64'(0));
    issue(32'hDEAD_BEEF, 32'h0000_1111, 1'b0, 1'b1, 1'b1);
    collect("t4_next");
    release_result("t4_next");

    // 5: asynchronous reset during the second RUN cycle aborts the operation
    issue(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("t5_rst_out_valid", 64'(out_valid), 64'(0));
    check("t5_rst_s", 64'(s), 64'(0));
    check("t5_rst_cout", 64'(cout), 64'(0));
    @(negedge clk);
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      #1;
      if (out_valid) seen = 1'b1;
    end
    check("t5_no_stale_valid", 64'(seen), 64'(0));
    issue(32'h0000_080E, 32'h0001_0100, 1'b0, 1'b0, 1'b1);
    collect("t5");
    check("t5_s_direct", 64'(s), 64'h0001_090E);
    release_result("t5");

`ifdef ADD_OVERFLOW_EN
    // 6: signed overflow
    issue(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 1'b1);
    collect("t6");
    check("t6_ovf_direct", 64'(ovf), 64'h1);
    check("t6_s_direct", 64'(s), 64'h8000_0000);
    release_result("t6");
`endif

    // Random operations
    for (int i = 0; i < 8; i++) begin
      ra = $urandom; rb = $urandom;
      rc = 1'($urandom_range(1)); rs = 1'($urandom_range(1));
      issue(ra, rb, rc, rs, 1'b1);
      collect("rand");
      release_result("rand");
    end

    check("final_queue_empty", 64'(exp_q.size()), 64'(0));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: observed=timeout expected=finish");
    $fatal(1, "timeout");
  end

endmodule
